// File: rtl/voice_scheduler.sv
// Voice scheduler: sweeps the per-sample ADSR pipeline over all voices and allocates
// voices to MIDI note events, pacing key-update strobes to one per pipeline key-update slot.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sample_tick,
    input  logic       i_note_valid,
    output logic       o_note_ready,
    input  logic       i_note_on,
    input  logic [6:0] i_note_num,
    output logic [1:0] o_pipeline_state,
    output logic [7:0] o_voice_index,
    output logic       o_key_flag,
    output logic       o_key_status,
    output logic [7:0] o_key_voice,
    output logic       o_tick_overrun,
    output logic       o_steal
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NUM_VOICES - 1);

    localparam logic [1:0] PsRead    = 2'd0;
    localparam logic [1:0] PsCompute = 2'd1;
    localparam logic [1:0] PsKey     = 2'd2;
    localparam logic [1:0] PsIdle    = 2'd3;

    typedef enum logic [1:0] {AlIdle, AlScan, AlIssue} al_state_e;

    // ---------------- pipeline sweep ----------------
    logic [1:0]    r_pstate;
    logic [IW-1:0] r_voice;
    logic          r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pstate  <= PsIdle;
            r_voice   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_sample_tick && (r_pstate != PsIdle);
            case (r_pstate)
                PsIdle: begin
                    if (i_sample_tick) begin
                        r_pstate <= PsRead;
                        r_voice  <= '0;
                    end
                end
                PsRead:    r_pstate <= PsCompute;
                PsCompute: r_pstate <= PsKey;
                default: begin
                    if (r_voice == LastIdx) begin
                        r_pstate <= PsIdle;
                    end else begin
                        r_pstate <= PsRead;
                        r_voice  <= r_voice + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- voice allocator ----------------
    al_state_e     r_al_state;
    al_state_e     w_al_next;
    logic          r_active [NUM_VOICES];
    logic [6:0]    r_note   [NUM_VOICES];
    logic          r_ev_on;
    logic [6:0]    r_ev_note;
    logic [IW-1:0] r_scan_idx;
    logic          r_match_found;
    logic [IW-1:0] r_match_idx;
    logic          r_free_found;
    logic [IW-1:0] r_free_idx;
    logic [IW-1:0] r_steal_ptr;
    logic          r_credit;
    logic          r_key_status;
    logic [IW-1:0] r_key_voice;

    logic          w_ready;
    logic          w_accept;
    logic          w_match_cur;
    logic          w_match_any;
    logic          w_fire;
    logic          w_steal_case;
    logic [IW-1:0] w_target;

    assign w_ready      = (r_al_state == AlIdle) && !i_reset;
    assign w_accept     = i_note_valid && w_ready;
    assign w_match_cur  = r_active[r_scan_idx] && (r_note[r_scan_idx] == r_ev_note);
    assign w_match_any  = r_match_found || w_match_cur;
    assign w_steal_case = r_ev_on && !r_match_found && !r_free_found;
    assign w_target     = r_match_found ? r_match_idx :
                          (r_ev_on && r_free_found) ? r_free_idx : r_steal_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_al_state <= AlIdle;
        end else begin
            r_al_state <= w_al_next;
        end
    end

    always_comb begin
        w_al_next = r_al_state;
        w_fire    = 1'b0;
        case (r_al_state)
            AlIdle: begin
                if (w_accept) begin
                    w_al_next = AlScan;
                end
            end
            AlScan: begin
                if (r_scan_idx == LastIdx) begin
                    // An unmatched note-off has nothing to deliver.
                    w_al_next = (!r_ev_on && !w_match_any) ? AlIdle : AlIssue;
                end
            end
            AlIssue: begin
                if (r_credit && (r_pstate != PsKey) && !i_reset) begin
                    w_fire    = 1'b1;
                    w_al_next = AlIdle;
                end
            end
            default: w_al_next = AlIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                r_active[i] <= 1'b0;
                r_note[i]   <= '0;
            end
            r_ev_on       <= 1'b0;
            r_ev_note     <= '0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_steal_ptr   <= '0;
            r_credit      <= 1'b1;
            r_key_status  <= 1'b0;
            r_key_voice   <= '0;
        end else begin
            if (w_accept) begin
                r_ev_on       <= i_note_on;
                r_ev_note     <= i_note_num;
                r_scan_idx    <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
            end
            if (r_al_state == AlScan) begin
                if (!r_match_found && w_match_cur) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_scan_idx;
                end
                if (!r_free_found && !r_active[r_scan_idx]) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_scan_idx;
                end
                if (r_scan_idx != LastIdx) begin
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
            end
            // Credit returns only on a key-update slot after the strobe, so the ADSR
            // pending entry has drained before the next strobe.
            if (w_fire) begin
                r_credit     <= 1'b0;
                r_key_status <= r_ev_on;
                r_key_voice  <= w_target;
                if (r_ev_on) begin
                    r_active[w_target] <= 1'b1;
                    r_note[w_target]   <= r_ev_note;
                end else begin
                    r_active[w_target] <= 1'b0;
                end
                if (w_steal_case) begin
                    r_steal_ptr <= (r_steal_ptr == LastIdx) ? '0 : r_steal_ptr + 1'b1;
                end
            end else if (r_pstate == PsKey) begin
                r_credit <= 1'b1;
            end
        end
    end

    assign o_note_ready     = w_ready;
    assign o_pipeline_state = r_pstate;
    assign o_voice_index    = 8'(r_voice);
    assign o_tick_overrun   = r_overrun;
    assign o_key_flag       = w_fire;
    assign o_key_status     = w_fire ? r_ev_on : r_key_status;
    assign o_key_voice      = 8'(w_fire ? w_target : r_key_voice);
    assign o_steal          = w_fire && w_steal_case;

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized scoreboard bench for voice_scheduler: a behavioural allocation/sweep model
// predicts every key strobe and per-cycle sweep output.
module tb_voice_scheduler;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       nvalid = 1'b0;
    logic       non = 1'b0;
    logic [6:0] nnum = '0;
    logic       o_note_ready;
    logic [1:0] o_pipeline_state;
    logic [7:0] o_voice_index;
    logic       o_key_flag;
    logic       o_key_status;
    logic [7:0] o_key_voice;
    logic       o_tick_overrun;
    logic       o_steal;

    voice_scheduler #(.NUM_VOICES(N)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_sample_tick   (tick),
        .i_note_valid    (nvalid),
        .o_note_ready    (o_note_ready),
        .i_note_on       (non),
        .i_note_num      (nnum),
        .o_pipeline_state(o_pipeline_state),
        .o_voice_index   (o_voice_index),
        .o_key_flag      (o_key_flag),
        .o_key_status    (o_key_status),
        .o_key_voice     (o_key_voice),
        .o_tick_overrun  (o_tick_overrun),
        .o_steal         (o_steal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit status;
        int voice;
        bit steal;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   m_act [N];
    int   m_note[N];
    int   m_sp = 0;
    int   sw_pos = -1;
    int   sw_last = 0;
    bit   sw_ovr = 0;
    int   tick_req = 0;
    int   tick_done = 0;
    bit   tick_en = 0;
    bit   seen_s2 = 1;
    int   nonidle = 0;
    int   ovr_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sweep reference: a position counter over the 3*N-cycle sweep.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sw_pos  = -1;
            sw_last = 0;
            sw_ovr  = 0;
        end else begin
            sw_ovr = tick && (sw_pos >= 0);
            if (sw_pos >= 0) begin
                sw_pos++;
                if (sw_pos == 3 * N) sw_pos = -1;
            end else if (tick) begin
                sw_pos = 0;
            end
            if (sw_pos >= 0) sw_last = sw_pos / 3;
        end
    end

    // Tick driver: directed requests take priority over random ticks.
    initial forever begin
        @(posedge clk);
        #2;
        if (tick_req != tick_done) begin
            tick = 1'b1;
            tick_done++;
        end else begin
            tick = tick_en && ($urandom_range(0, 24) == 0);
        end
    end

    // Monitor: sweep outputs every cycle, key strobes against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) seen_s2 = 1;
        check("pipeline_state", int'(o_pipeline_state), (sw_pos < 0) ? 3 : sw_pos % 3);
        check("voice_index", int'(o_voice_index), sw_last);
        check("tick_overrun", int'(o_tick_overrun), int'(sw_ovr));
        if (o_pipeline_state != 2'd3) nonidle++;
        if (o_tick_overrun) ovr_cnt++;
        if (o_key_flag) begin
            if (sbq.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("key_status", int'(o_key_status), int'(e.status));
                check("key_voice", int'(o_key_voice), e.voice);
                check("steal", int'(o_steal), int'(e.steal));
                check("latency_min", int'((cyc - e.acc) >= N + 1), 1);
            end
            check("strobe_paced", int'(seen_s2 && (o_pipeline_state != 2'd2)), 1);
            seen_s2 = 0;
        end else if (o_steal) begin
            check("steal_without_strobe", 1, 0);
        end
        if (o_pipeline_state == 2'd2) seen_s2 = 1;
    end

    function automatic void model_accept(input bit on, input int num);
        int   match = -1;
        int   free = -1;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && m_note[i] == num && match < 0) match = i;
            if (!m_act[i] && free < 0) free = i;
        end
        e.status = on;
        e.steal  = 0;
        e.acc    = cyc;
        if (on) begin
            if (match >= 0) e.voice = match;
            else if (free >= 0) e.voice = free;
            else begin
                e.voice = m_sp;
                e.steal = 1;
                m_sp = (m_sp + 1) % N;
            end
            m_act[e.voice]  = 1;
            m_note[e.voice] = num;
            sbq.push_back(e);
        end else if (match >= 0) begin
            e.voice = match;
            m_act[match] = 0;
            sbq.push_back(e);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = 0;
            m_note[i] = 0;
        end
        m_sp = 0;
        sbq.delete();
    endfunction

    task automatic send(input bit on, input int num);
        int  b = 0;
        bit  ok = 0;
        @(posedge clk);
        #1;
        nvalid = 1'b1;
        non    = on;
        nnum   = 7'(num);
        while (!ok && b < 3000) begin
            @(negedge clk);
            if (o_note_ready) ok = 1;
            else b++;
        end
        check("accept_in_time", int'(ok), 1);
        if (ok) model_accept(on, num);
        @(posedge clk);
        #1;
        nvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int b = 0;
        bit ok = 0;
        while (!ok && b < 4000) begin
            @(negedge clk);
            if (sbq.size() == 0 && o_note_ready) ok = 1;
            else b++;
        end
        check("drain_in_time", int'(ok), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int b;
        model_reset();
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(o_note_ready), 0);
        check("rst_key_flag", int'(o_key_flag), 0);
        check("rst_key_status", int'(o_key_status), 0);
        check("rst_key_voice", int'(o_key_voice), 0);
        check("rst_steal", int'(o_steal), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nonidle = 0;
        ovr_cnt = 0;

        // Directed sweep with one overrun tick partway through
        @(posedge clk);
        #1;
        tick_req++;
        repeat (11) @(posedge clk);
        #1;
        tick_req++;
        repeat (40) @(posedge clk);
        check("sweep_length", nonidle, 3 * N);
        check("overrun_count", ovr_cnt, 1);

        // Directed allocation with sweeps running
        tick_en = 1;
        send(1, 60);
        send(1, 64);
        send(1, 62);
        send(1, 63);
        wait_drain();
        send(0, 62);
        send(0, 63);
        send(0, 60);
        wait_drain();
        send(0, 60);
        k = 0;
        while (!o_note_ready && k < 50) begin
            @(negedge clk);
            if (!o_note_ready) k++;
        end
        check("noff_nomatch_ready", int'(k >= N - 1 && k <= N + 2), 1);
        check("noff_nomatch_no_strobe", sbq.size(), 0);
        for (int n = 65; n <= 71; n++) send(1, n);
        send(1, 72);
        send(1, 73);
        wait_drain();

        // Randomized events
        for (int i = 0; i < 60; i++) begin
            send(($urandom_range(0, 2) != 0), 60 + $urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(posedge clk);
        end
        wait_drain();

        // Credit stall: no ticks after a strobe holds the next event in issue
        tick_en = 0;
        b = 0;
        while (b < 200 && o_pipeline_state != 2'd3) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #1;
        tick_req++;
        repeat (3 * N + 5) @(posedge clk);
        send(1, 50);
        wait_drain();
        send(1, 51);
        repeat (40) begin
            @(negedge clk);
            check("stall_ready_low", int'(o_note_ready), 0);
        end
        check("stall_pending", sbq.size(), 1);
        @(posedge clk);
        #1;
        tick_req++;
        wait_drain();

        // Reset during scan discards the event and empties the table
        tick_en = 1;
        send(1, 70);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("reset_ready_low", int'(o_note_ready), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", int'(o_note_ready), 1);
        send(1, 70);
        send(1, 71);
        wait_drain();
        check("final_queue_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Controller sitting in front of the ADSR envelope block.
- Sequences the per-sample pipeline sweep: drives pipeline_state and voice_index across all voices once per audio sample tick.
- Allocates voices to incoming MIDI note-on/note-off events from a valid/ready source.
- Delivers each key update through the ADSR's single-entry flag/status/voice update port, pacing strobes so that none is dropped.

Parameters:
- NUM_VOICES, 8, number of voices swept and allocated (2..256).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_sample_tick  in  1  one-cycle pulse at audio sample rate; starts a sweep
- i_note_valid  in  1  note event valid
- o_note_ready  out  1  scheduler can accept a note event
- i_note_on  in  1  1 = note-on, 0 = note-off
- i_note_num  in  7  MIDI note number
- o_pipeline_state  out  2  0 read, 1 compute, 2 key update, 3 idle
- o_voice_index  out  8  voice currently in the pipeline
- o_key_flag  out  1  one-cycle key update strobe to ADSR
- o_key_status  out  1  keystate carried with o_key_flag
- o_key_voice  out  8  voice index carried with o_key_flag
- o_tick_overrun  out  1  one-cycle pulse when a tick arrives during a sweep
- o_steal  out  1  one-cycle pulse when a note-on steals a voice

Behaviour:
- Reset values: o_pipeline_state=3, o_voice_index=0, o_key_flag=0, o_key_status=0, o_key_voice=0, o_tick_overrun=0, o_steal=0. All table entries inactive. steal_ptr=0. key_credit=1. Allocator IDLE. o_note_ready=0 while i_reset is high.

Sweep:
- Idle (state 3): tick -> next cycle starts voice 0 in state 0.
- Each voice occupies states 0,1,2 for exactly one cycle each. After state 2 of voice v<NUM_VOICES-1, go to state 0 of voice v+1. After the last voice, go to state 3.
- o_voice_index holds during states 0-2 and keeps its last value in idle.
- Sweep length is 3*NUM_VOICES cycles.
- A tick arriving while not idle is ignored and pulses o_tick_overrun the next cycle.
- A tick arriving on the final state-2 cycle also counts as an overrun.

Note table:
- NUM_VOICES entries of {active, note[6:0]}.

Allocator FSM IDLE -> SCAN -> ISSUE -> IDLE:
- o_note_ready is high iff IDLE (combinational, gated by reset). The event is accepted on valid&&ready and latched.
- SCAN examines one entry per cycle, index 0..NUM_VOICES-1, for exactly NUM_VOICES cycles. It records:
  - the lowest active entry whose note equals i_note_num (match);
  - the lowest inactive entry (free).
- Note-on target, in priority: match (retrigger), else free, else steal_ptr. On a steal, pulse o_steal and set steal_ptr=(steal_ptr+1) mod NUM_VOICES.
- Note-off target: match. With no match, return to IDLE with no strobe and no table change.
- ISSUE waits until key_credit=1 and o_pipeline_state!=2. Then for one cycle: o_key_flag=1, o_key_status=i_note_on, o_key_voice=target.
  - Note-on: table[target]={1,note}.
  - Note-off: table[target].active=0.
  - Clear key_credit, then return to IDLE.
- key_credit is set on any cycle with o_pipeline_state==2 strictly after the strobe cycle. This guarantees the ADSR pending buffer has cleared before the next strobe.
- With no sweeps running, credit is not restored and ISSUE stalls; ready stays low (backpressure).
- Minimum event latency: accept at cycle 0, strobe at cycle NUM_VOICES+1.
- o_key_voice/o_key_status hold their values after the strobe.
- The sweep and the allocator run independently; reset mid-operation aborts both immediately and discards the latched event.

Test Plan:
- Reset, then tick -> o_pipeline_state sequence 0,1,2 per voice for voices 0..7 (24 cycles), then 3; second tick at sweep cycle 10 -> o_tick_overrun pulse, sweep length unchanged.
- Note-on 60 with sweeps running -> ready drops, o_key_flag at cycle 9 after accept (state!=2) with status=1, voice=0; note-on 64 -> voice 1.
- Two back-to-back note-ons -> second strobe not earlier than the cycle after a state-2 cycle following the first strobe; no two strobes without an intervening state 2.
- Note-off 60 -> strobe status=0, voice=0; a further note-off 60 -> no strobe, ready returns after 8 scan cycles.
- Fill all 8 voices, note-on 72 -> o_steal pulse, strobe voice=0, steal_ptr=1; next overflow note-on steals voice 1.
- No ticks after one strobe, second event -> ISSUE stalls, no strobe, ready low; tick -> strobe after the first state-2 cycle. Assert reset during SCAN -> ready=0 during reset, then 1, table empty.
